alu_serial_ctrl: RTL

ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

---
 rtl/alu_serial_pkg.sv | 23 ++
 rtl/alu1bit.sv | 46 ++++
 rtl/alu_serial_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/alu_serial_pkg.sv
// Shared definitions for the bit-serial ALU controller: operation encoding,
// FSM state encoding and a small operation-class helper.
package alu_serial_pkg;

  typedef enum logic [1:0] {
    OP_NOR = 2'b00,
    OP_XOR = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // ADD and SUB propagate a carry; the bitwise operations do not.
  function automatic logic op_is_arith(input op_e i_op);
    return (i_op == OP_ADD) || (i_op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu1bit.sv
// One-bit ALU slice used by the serial controller. SUB is computed as
// a + ~b + cin, with the controller seeding cin=1 on the first bit.
module alu1bit
  import alu_serial_pkg::*;
(
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  input  op_e  i_op,
  output logic o_sum,
  output logic o_cout
);

  logic w_b_eff;

  // Bit function and carry for the selected operation.
  always_comb begin
    w_b_eff = 1'b0;
    o_sum   = 1'b0;
    o_cout  = 1'b0;
    if (i_op == OP_SUB) begin
      w_b_eff = ~i_b;
    end else begin
      w_b_eff = i_b;
    end
    case (i_op)
      OP_NOR: begin
        o_sum  = ~(i_a | i_b);
        o_cout = 1'b0;
      end
      OP_XOR: begin
        o_sum  = i_a ^ i_b;
        o_cout = 1'b0;
      end
      OP_ADD, OP_SUB: begin
        o_sum  = i_a ^ w_b_eff ^ i_cin;
        o_cout = (i_a & w_b_eff) | (i_a & i_cin) | (w_b_eff & i_cin);
      end
      default: begin
        o_sum  = 1'b0;
        o_cout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU controller: processes WIDTH operand bits LSB first through a
// single alu1bit slice. Define ALU_SERIAL_OVF_EN to enable signed-overflow output.
module alu_serial_ctrl
  import alu_serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  op_e              r_op;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             w_sum;
  logic             w_cout;
  logic             w_accept;
  logic             w_last;

  assign w_accept = (r_state == IDLE) && start;
  assign w_last   = (r_state == RUN) && (r_cnt == LAST_BIT);

  // Operand copies shift right each RUN cycle, so bit 0 is always the live bit.
  alu1bit u_alu (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_cin  (r_carry),
    .i_op   (r_op),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic; start only matters in IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = RUN;
        end else begin
          w_state_next = IDLE;
        end
      end
      RUN: begin
        if (w_last) begin
          w_state_next = DONE;
        end else begin
          w_state_next = RUN;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // FSM outputs decoded from the state register.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        done = 1'b0;
      end
      RUN: begin
        busy = 1'b1;
        done = 1'b0;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Datapath: capture on accept, then one bit per RUN cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a      <= {WIDTH{1'b0}};
      r_b      <= {WIDTH{1'b0}};
      r_result <= {WIDTH{1'b0}};
      r_op     <= OP_NOR;
      r_cnt    <= {CW{1'b0}};
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_op    <= op_e'(op);
      r_cnt   <= {CW{1'b0}};
      r_carry <= (op == 2'b11) ? 1'b1 : 1'b0;
    end else if (r_state == RUN) begin
      r_a      <= {1'b0, r_a[WIDTH-1:1]};
      r_b      <= {1'b0, r_b[WIDTH-1:1]};
      r_result <= {w_sum, r_result[WIDTH-1:1]};
      r_carry  <= w_cout;
      if (w_last) begin
        // Clear rather than increment so the counter never reaches WIDTH.
        r_cnt  <= {CW{1'b0}};
        r_cout <= op_is_arith(r_op) ? w_cout : 1'b0;
      end else begin
        r_cnt  <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

  assign result = r_result;
  assign cout   = r_cout;

`ifdef ALU_SERIAL_OVF_EN
  logic r_ovf;

  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_last) begin
      r_ovf <= op_is_arith(r_op) ? (r_carry ^ w_cout) : 1'b0;
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

endmodule
